// File: rtl/mux_rr_pkg.sv
// Shared types and defaults for the mux_rr_feeder slice: grant encoding and the
// round-robin pick helper used by the top-level arbiter.
package mux_rr_pkg;

  localparam int unsigned MUX_RR_W     = 8;
  localparam int unsigned MUX_RR_CNT_W = 16;

  typedef enum logic {
    GNT_X1 = 1'b0,
    GNT_X2 = 1'b1
  } gnt_t;

  // Channel to grant when at least one slot holds data; on a tie the channel
  // that did not win last time goes next.
  function automatic gnt_t rr_pick(input logic full1, input logic full2, input gnt_t last);
    gnt_t pick;
    if (full1 && full2) begin
      pick = (last == GNT_X1) ? GNT_X2 : GNT_X1;
    end else if (full2) begin
      pick = GNT_X2;
    end else begin
      pick = GNT_X1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_rr_feeder_hold_slot.sv
// hold_slot: one-entry valid/ready holding register. Accepts a beat only while
// empty, so the upstream ready is a plain flop output.
module hold_slot
  import mux_rr_pkg::*;
#(
  parameter int unsigned W = MUX_RR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] data_i,
  input  logic         vld_i,
  output logic         rdy_o,
  input  logic         pop_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q;
  logic         full_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Fill and pop never coincide: a fill needs the slot empty, a pop needs it full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (vld_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign rdy_o  = ~full_q;
  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/mux_rr_feeder.sv
// mux_rr_feeder: two buffered byte streams, round-robin arbitrated into a
// registered {x1_o, x2_o, sel_o} triple. Grant counters exist only when
// MUX_RR_STATS_EN is defined.
module mux_rr_feeder
  import mux_rr_pkg::*;
#(
  parameter int unsigned W = MUX_RR_W
`ifdef MUX_RR_STATS_EN
  , parameter int unsigned CNT_W = MUX_RR_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     x1_i,
  input  logic             x1_vld_i,
  output logic             x1_rdy_o,
  input  logic [W-1:0]     x2_i,
  input  logic             x2_vld_i,
  output logic             x2_rdy_o,
  output logic [W-1:0]     x1_o,
  output logic [W-1:0]     x2_o,
  output logic             sel_o,
  output logic             vld_o,
  input  logic             rdy_i
`ifdef MUX_RR_STATS_EN
  , output logic [CNT_W-1:0] x1_gnt_cnt_o
  , output logic [CNT_W-1:0] x2_gnt_cnt_o
`endif
);

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // valid holds its payload until then, and every ready here is a flop output.

  logic         s1_full;
  logic         s2_full;
  logic [W-1:0] s1_data;
  logic [W-1:0] s2_data;
  logic         pop1;
  logic         pop2;

  logic         out_free;
  logic         any_full;
  logic         gnt_fire;
  gnt_t         gnt;

  gnt_t         last_gnt_q;
  gnt_t         sel_q;
  logic         vld_q;
  logic [W-1:0] x1_q;
  logic [W-1:0] x2_q;

  hold_slot #(.W(W)) u_slot1 (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (x1_i),
    .vld_i   (x1_vld_i),
    .rdy_o   (x1_rdy_o),
    .pop_i   (pop1),
    .full_o  (s1_full),
    .data_o  (s1_data)
  );

  hold_slot #(.W(W)) u_slot2 (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (x2_i),
    .vld_i   (x2_vld_i),
    .rdy_o   (x2_rdy_o),
    .pop_i   (pop2),
    .full_o  (s2_full),
    .data_o  (s2_data)
  );

  always_comb begin
    out_free = ~vld_q | rdy_i;
    any_full = s1_full | s2_full;
    gnt      = rr_pick(s1_full, s2_full, last_gnt_q);
    gnt_fire = out_free & any_full;
    pop1     = gnt_fire & (gnt == GNT_X1);
    pop2     = gnt_fire & (gnt == GNT_X2);
  end

  // Output triple plus the last-grant state; both operands load on every grant
  // so the mux always sees flop outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= GNT_X2;
      sel_q      <= GNT_X1;
      vld_q      <= 1'b0;
      x1_q       <= '0;
      x2_q       <= '0;
    end else if (out_free) begin
      if (any_full) begin
        x1_q  <= s1_data;
        x2_q  <= s2_data;
        sel_q <= gnt;
        vld_q <= 1'b1;
        case (last_gnt_q)
          GNT_X1:  if (gnt == GNT_X2) last_gnt_q <= GNT_X2;
          GNT_X2:  if (gnt == GNT_X1) last_gnt_q <= GNT_X1;
          default: last_gnt_q <= GNT_X2;
        endcase
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

  assign x1_o  = x1_q;
  assign x2_o  = x2_q;
  assign sel_o = sel_q;
  assign vld_o = vld_q;

`ifdef MUX_RR_STATS_EN
  logic [CNT_W-1:0] x1_cnt_q;
  logic [CNT_W-1:0] x1_cnt_d;
  logic [CNT_W-1:0] x2_cnt_q;
  logic [CNT_W-1:0] x2_cnt_d;

  // Saturating: a pinned all-ones value means "at least this many".
  always_comb begin
    x1_cnt_d = x1_cnt_q;
    x2_cnt_d = x2_cnt_q;
    if (pop1 && (x1_cnt_q != '1)) x1_cnt_d = x1_cnt_q + CNT_W'(1);
    if (pop2 && (x2_cnt_q != '1)) x2_cnt_d = x2_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x1_cnt_q <= '0;
      x2_cnt_q <= '0;
    end else begin
      x1_cnt_q <= x1_cnt_d;
      x2_cnt_q <= x2_cnt_d;
    end
  end

  assign x1_gnt_cnt_o = x1_cnt_q;
  assign x2_gnt_cnt_o = x2_cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_feeder.sv
// Bench for mux_rr_feeder: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mux_rr_feeder;

  logic       clk;
  logic       reset_n;
  logic [7:0] x1_i;
  logic       x1_vld_i;
  logic       x1_rdy_o;
  logic [7:0] x2_i;
  logic       x2_vld_i;
  logic       x2_rdy_o;
  logic [7:0] x1_o;
  logic [7:0] x2_o;
  logic       sel_o;
  logic       vld_o;
  logic       rdy_i;
`ifdef MUX_RR_STATS_EN
  logic [15:0] x1_gnt_cnt_o;
  logic [15:0] x2_gnt_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mux_rr_feeder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .x1_i     (x1_i),
    .x1_vld_i (x1_vld_i),
    .x1_rdy_o (x1_rdy_o),
    .x2_i     (x2_i),
    .x2_vld_i (x2_vld_i),
    .x2_rdy_o (x2_rdy_o),
    .x1_o     (x1_o),
    .x2_o     (x2_o),
    .sel_o    (sel_o),
    .vld_o    (vld_o),
    .rdy_i    (rdy_i)
`ifdef MUX_RR_STATS_EN
    , .x1_gnt_cnt_o (x1_gnt_cnt_o)
    , .x2_gnt_cnt_o (x2_gnt_cnt_o)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel queues of accepted-but-not-granted bytes
  // (at most one each), and the beat currently presented downstream.
  logic [7:0]  exp_q1[$];
  logic [7:0]  exp_q2[$];
  bit          m_vld  = 1'b0;
  bit          m_sel  = 1'b0;
  logic [7:0]  m_data = 8'h00;
  bit          m_last = 1'b1;
  logic [15:0] m_cnt1 = 16'h0;
  logic [15:0] m_cnt2 = 16'h0;
  bit          m_e1;
  bit          m_e2;
  bit          m_pick;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q1.delete();
        exp_q2.delete();
        m_vld  = 1'b0;
        m_sel  = 1'b0;
        m_data = 8'h00;
        m_last = 1'b1;
        m_cnt1 = 16'h0;
        m_cnt2 = 16'h0;
      end else begin
        m_e1 = (exp_q1.size() == 0);
        m_e2 = (exp_q2.size() == 0);
        if (!m_vld || rdy_i) begin
          if (m_e1 && m_e2) begin
            m_vld = 1'b0;
          end else begin
            m_pick = (!m_e1 && !m_e2) ? !m_last : m_e1;
            m_data = m_pick ? exp_q2.pop_front() : exp_q1.pop_front();
            m_sel  = m_pick;
            m_vld  = 1'b1;
            m_last = m_pick;
            if (m_pick) begin
              if (m_cnt2 != 16'hFFFF) m_cnt2 = m_cnt2 + 16'h1;
            end else begin
              if (m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'h1;
            end
          end
        end
        if (x1_vld_i && m_e1) exp_q1.push_back(x1_i);
        if (x2_vld_i && m_e2) exp_q2.push_back(x2_i);
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("vld_o", 32'(vld_o), 32'(m_vld));
      chk("x1_rdy_o", 32'(x1_rdy_o), 32'(exp_q1.size() == 0));
      chk("x2_rdy_o", 32'(x2_rdy_o), 32'(exp_q2.size() == 0));
      if (m_vld) begin
        chk("sel_o", 32'(sel_o), 32'(m_sel));
        chk("operand", 32'(sel_o ? x2_o : x1_o), 32'(m_data));
      end
`ifdef MUX_RR_STATS_EN
      chk("x1_gnt_cnt", 32'(x1_gnt_cnt_o), 32'(m_cnt1));
      chk("x2_gnt_cnt", 32'(x2_gnt_cnt_o), 32'(m_cnt2));
`endif
    end
  end

  // Log of beats that left the block: {sel, selected operand}.
  logic [8:0] fired[$];
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && vld_o && rdy_i) fired.push_back({sel_o, sel_o ? x2_o : x1_o});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic drive(input bit v1, input logic [7:0] d1, input bit v2, input logic [7:0] d2);
    x1_vld_i = v1;
    x1_i     = d1;
    x2_vld_i = v2;
    x2_i     = d2;
  endtask

  int  i1;
  int  i2;
  int  cyc;
  bit  a1;
  bit  a2;
  logic [8:0] exp_beat;

  initial begin
    reset_n = 1'b0;
    rdy_i   = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    step();
    chk("reset_vld", 32'(vld_o), 32'h0);
    chk("reset_sel", 32'(sel_o), 32'h0);
    chk("reset_rdy1", 32'(x1_rdy_o), 32'h1);
    chk("reset_rdy2", 32'(x2_rdy_o), 32'h1);
    chk("reset_x1", 32'(x1_o), 32'h0);
    chk("reset_x2", 32'(x2_o), 32'h0);
    reset_n = 1'b1;
    step();

    // single beat: accepted at edge N, presented after edge N+1
    rdy_i = 1'b1;
    drive(1'b1, 8'hA5, 1'b0, 8'h00);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("single_rdy1_busy", 32'(x1_rdy_o), 32'h0);
    chk("single_vld_early", 32'(vld_o), 32'h0);
    step();
    chk("single_vld", 32'(vld_o), 32'h1);
    chk("single_sel", 32'(sel_o), 32'h0);
    chk("single_x1", 32'(x1_o), 32'hA5);
    step();
    chk("single_drained", 32'(vld_o), 32'h0);

    // tie from a fresh reset goes to x1 first
    apply_reset();
    drive(1'b1, 8'h11, 1'b1, 8'h22);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    chk("tie_first_sel", 32'(sel_o), 32'h0);
    chk("tie_first_x1", 32'(x1_o), 32'h11);
    step();
    chk("tie_second_sel", 32'(sel_o), 32'h1);
    chk("tie_second_x2", 32'(x2_o), 32'h22);
    step();
    chk("tie_drained", 32'(vld_o), 32'h0);

    // fairness: both channels streaming 10 beats each
    fired.delete();
    i1  = 0;
    i2  = 0;
    cyc = 0;
    while ((i1 < 10 || i2 < 10) && cyc < 200) begin
      drive(i1 < 10, 8'(8'h30 + i1), i2 < 10, 8'(8'h40 + i2));
      a1 = x1_vld_i && x1_rdy_o;
      a2 = x2_vld_i && x2_rdy_o;
      step();
      cyc++;
      if (a1) i1++;
      if (a2) i2++;
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("stream_timeout", 32'(cyc < 200), 32'h1);
    repeat (4) step();
    chk("fair_count", 32'(fired.size()), 32'd20);
    for (int k = 0; k < 20; k++) begin
      exp_beat = (k % 2 == 0) ? {1'b0, 8'(8'h30 + k / 2)} : {1'b1, 8'(8'h40 + k / 2)};
      if (k < fired.size()) chk("fair_beat", 32'(fired[k]), 32'(exp_beat));
    end

    // backpressure: hold the triple with both slots filling behind it
    rdy_i = 1'b0;
    drive(1'b1, 8'hA1, 1'b1, 8'hB2);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    step();
    drive(1'b1, 8'hA3, 1'b0, 8'h00);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld", 32'(vld_o), 32'h1);
      chk("bp_sel", 32'(sel_o), 32'h0);
      chk("bp_x1", 32'(x1_o), 32'hA1);
      chk("bp_rdy1", 32'(x1_rdy_o), 32'h0);
      chk("bp_rdy2", 32'(x2_rdy_o), 32'h0);
      step();
    end
    fired.delete();
    rdy_i = 1'b1;
    repeat (5) step();
    chk("bp_drain_count", 32'(fired.size()), 32'd3);
    if (fired.size() == 3) begin
      chk("bp_drain0", 32'(fired[0]), 32'h0A1);
      chk("bp_drain1", 32'(fired[1]), 32'h1B2);
      chk("bp_drain2", 32'(fired[2]), 32'h0A3);
    end

    // reset in the middle of a transfer discards buffered data
    rdy_i = 1'b0;
    drive(1'b1, 8'hC1, 1'b1, 8'hC2);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    chk("mid_rdy1_full", 32'(x1_rdy_o), 32'h0);
    chk("mid_rdy2_full", 32'(x2_rdy_o), 32'h0);
    step();
    chk("mid_vld_before", 32'(vld_o), 32'h1);
    reset_n = 1'b0;
    step();
    chk("mid_vld", 32'(vld_o), 32'h0);
    chk("mid_rdy1", 32'(x1_rdy_o), 32'h1);
    chk("mid_rdy2", 32'(x2_rdy_o), 32'h1);
    chk("mid_x1", 32'(x1_o), 32'h0);
`ifdef MUX_RR_STATS_EN
    chk("mid_cnt1", 32'(x1_gnt_cnt_o), 32'h0);
    chk("mid_cnt2", 32'(x2_gnt_cnt_o), 32'h0);
`endif
    reset_n = 1'b1;
    step();
    fired.delete();
    rdy_i = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 8'h77);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (4) step();
    chk("post_reset_count", 32'(fired.size()), 32'd1);
    if (fired.size() == 1) chk("post_reset_beat", 32'(fired[0]), 32'h177);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
